// File: rtl/fix_length_packetizer.sv
// Byte-to-word packetizer: packs an 8-bit Avalon-ST stream MSB-first into
// BYTES_PER_WORD-byte words and frames them into fixed-length packets with flush.
module fix_length_packetizer #(
    parameter int BYTES_PER_WORD = 4,
    parameter int LEN_W          = 13,
    parameter int DEFAULT_LEN    = 64
) (
    input  logic                                clock_clk,
    input  logic                                reset_reset,
    input  logic [LEN_W-1:0]                    pkt_len,
    input  logic                                flush_req,
    output logic                                flush_ack,
    input  logic [7:0]                          asi_in0_data,
    input  logic                                asi_in0_valid,
    output logic                                asi_in0_ready,
    output logic [8*BYTES_PER_WORD-1:0]         aso_out0_data,
    output logic                                aso_out0_valid,
    input  logic                                aso_out0_ready,
    output logic                                aso_out0_startofpacket,
    output logic                                aso_out0_endofpacket,
    output logic [$clog2(BYTES_PER_WORD)-1:0]   aso_out0_empty
);

    localparam int WORD_W = 8 * BYTES_PER_WORD;
    localparam int KW     = $clog2(BYTES_PER_WORD);
    localparam logic [KW-1:0]    K_LAST  = KW'(BYTES_PER_WORD - 1);
    localparam logic [LEN_W-1:0] DEF_LEN = LEN_W'(DEFAULT_LEN);

    logic [WORD_W-1:0] acc_q, acc_d, data_q, data_d;
    logic [KW-1:0]     k_q, k_d, empty_q, empty_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d, len_q, len_d;
    logic              valid_q, valid_d, sop_q, sop_d, eop_q, eop_d;
    logic              ack_q, ack_d, open_q, open_d;

    logic              out_free, in_ready, accept, complete, flush_exec, load, closing;
    logic [KW-1:0]     k_eff;
    logic [WORD_W-1:0] acc_next;
    logic [LEN_W-1:0]  cur_len;

    always_comb begin
        // NOTE: every variable gets a default first so no path infers a latch.
        out_free   = !valid_q || aso_out0_ready;
        in_ready   = !reset_reset && ((k_q != K_LAST) || (out_free && !flush_req));
        accept     = asi_in0_valid && in_ready;
        complete   = accept && (k_q == K_LAST);
        flush_exec = flush_req && out_free;

        // A byte taken in the flush cycle lands in the flushed word, so fold it in first.
        acc_next = acc_q;
        if (accept) begin
            acc_next[WORD_W-1-8*int'(k_q) -: 8] = asi_in0_data;
        end
        k_eff = accept ? k_q + KW'(1) : k_q;

        cur_len = open_q ? len_q : ((pkt_len == '0) ? DEF_LEN : pkt_len);
        load    = complete || (flush_exec && ((k_eff != '0) || open_q));
        closing = flush_exec || (wcnt_q == cur_len - LEN_W'(1));

        acc_d   = acc_next;
        k_d     = k_eff;
        data_d  = data_q;
        sop_d   = sop_q;
        eop_d   = eop_q;
        empty_d = empty_q;
        valid_d = valid_q && !aso_out0_ready;
        ack_d   = flush_exec;
        wcnt_d  = wcnt_q;
        open_d  = open_q;
        len_d   = len_q;

        if (load) begin
            data_d  = acc_next;
            valid_d = 1'b1;
            sop_d   = !open_q;
            eop_d   = closing;
            len_d   = cur_len;
            if (!flush_exec) begin
                empty_d = '0;
            end else if (k_eff != '0) begin
                empty_d = KW'(BYTES_PER_WORD - int'(k_eff));
            end else begin
                empty_d = K_LAST;
            end
            if (closing) begin
                wcnt_d = '0;
                open_d = 1'b0;
            end else begin
                wcnt_d = wcnt_q + LEN_W'(1);
                open_d = 1'b1;
            end
        end

        if (complete || flush_exec) begin
            acc_d = '0;
            k_d   = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock_clk or posedge reset_reset) begin
        if (reset_reset) begin
            acc_q   <= '0;
            k_q     <= '0;
            data_q  <= '0;
            sop_q   <= 1'b0;
            eop_q   <= 1'b0;
            empty_q <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            wcnt_q  <= '0;
            open_q  <= 1'b0;
            len_q   <= '0;
        end else begin
            acc_q   <= acc_d;
            k_q     <= k_d;
            data_q  <= data_d;
            sop_q   <= sop_d;
            eop_q   <= eop_d;
            empty_q <= empty_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            wcnt_q  <= wcnt_d;
            open_q  <= open_d;
            len_q   <= len_d;
        end
    end

    assign asi_in0_ready          = in_ready;
    assign flush_ack              = ack_q;
    assign aso_out0_data          = data_q;
    assign aso_out0_valid         = valid_q;
    assign aso_out0_startofpacket = sop_q;
    assign aso_out0_endofpacket   = eop_q;
    assign aso_out0_empty         = empty_q;

endmodule

// File: tb/tb_fix_length_packetizer.sv
// Directed bench for fix_length_packetizer (BPW=4): framing, backpressure,
// flush, default length and mid-packet reset against hand-computed words.
module tb_fix_length_packetizer;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
        logic [1:0]  empty;
        int          cyc;
    } word_t;

    logic        clock_clk = 1'b0;
    logic        reset_reset = 1'b0;
    logic [12:0] pkt_len = 13'd3;
    logic        flush_req = 1'b0;
    logic        flush_ack;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_sop, out_eop;
    logic [1:0]  out_empty;

    int    n_checks = 0;
    int    n_errors = 0;
    int    cyc = 0;
    int    last_acc = 0;
    int    ack_cnt = 0;
    int    acc_cyc[12];
    word_t words[$];
    word_t last_w;
    bit    hold_pend = 1'b0;
    logic [35:0] hold_val = '0;

    fix_length_packetizer #(.BYTES_PER_WORD(4), .LEN_W(13), .DEFAULT_LEN(64)) dut (
        .clock_clk              (clock_clk),
        .reset_reset            (reset_reset),
        .pkt_len                (pkt_len),
        .flush_req              (flush_req),
        .flush_ack              (flush_ack),
        .asi_in0_data           (in_data),
        .asi_in0_valid          (in_valid),
        .asi_in0_ready          (in_ready),
        .aso_out0_data          (out_data),
        .aso_out0_valid         (out_valid),
        .aso_out0_ready         (out_ready),
        .aso_out0_startofpacket (out_sop),
        .aso_out0_endofpacket   (out_eop),
        .aso_out0_empty         (out_empty)
    );

    always #5 clock_clk = ~clock_clk;
    always @(posedge clock_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Output monitor: records consumed words, checks stalled words stay stable, counts acks.
    always @(negedge clock_clk) begin
        if (hold_pend && out_valid && !reset_reset)
            check("hold_stable", {28'd0, out_data, out_sop, out_eop, out_empty}, {28'd0, hold_val});
        hold_pend = out_valid && !out_ready;
        hold_val  = {out_data, out_sop, out_eop, out_empty};
        if (out_valid && out_ready)
            words.push_back('{data: out_data, sop: out_sop, eop: out_eop, empty: out_empty, cyc: cyc});
        if (flush_ack) ack_cnt++;
    end

    task automatic send_byte(input logic [7:0] b);
        bit done = 1'b0;
        bit took;
        in_data  = b;
        in_valid = 1'b1;
        for (int t = 0; t < 200 && !done; t++) begin
            @(negedge clock_clk);
            took = in_ready;
            @(posedge clock_clk);
            #1;
            if (took) done = 1'b1;
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
        last_acc = cyc;
    endtask

    task automatic send_seq(input int first, input int n);
        for (int i = 0; i < n; i++) send_byte(8'(first + i));
        in_valid = 1'b0;
    endtask

    task automatic expect_word(input string tag, input logic [31:0] d, input logic sop,
                               input logic eop, input logic [1:0] emp);
        for (int t = 0; t < 300 && words.size() == 0; t++) begin
            @(posedge clock_clk);
            #1;
        end
        if (words.size() == 0) begin
            check({tag, "_missing"}, 64'd0, 64'd1);
        end else begin
            last_w = words.pop_front();
            check(tag, {28'd0, last_w.data, last_w.sop, last_w.eop, last_w.empty},
                  {28'd0, d, sop, eop, emp});
        end
    endtask

    task automatic do_flush();
        bit got = 1'b0;
        flush_req = 1'b1;
        for (int t = 0; t < 50 && !got; t++) begin
            @(posedge clock_clk);
            #1;
            if (flush_ack) got = 1'b1;
        end
        flush_req = 1'b0;
        if (!got) check("flush_ack_timeout", 64'd0, 64'd1);
    endtask

    function automatic logic [31:0] mkw(input int b);
        return {8'(b), 8'(b + 1), 8'(b + 2), 8'(b + 3)};
    endfunction

    initial begin
        // Reset state
        #1 reset_reset = 1'b1;
        #3;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd0);
        check("rst_fields", {27'd0, out_data, out_sop, out_eop, out_empty, flush_ack}, 64'd0);
        repeat (3) @(posedge clock_clk);
        #1 reset_reset = 1'b0;
        @(posedge clock_clk);
        #1;
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        // T1: 3-word packet, continuous stream, latency
        pkt_len = 13'd3;
        for (int i = 0; i < 12; i++) begin
            send_byte(8'(i));
            acc_cyc[i] = last_acc;
        end
        in_valid = 1'b0;
        expect_word("t1_w0", 32'h00010203, 1'b1, 1'b0, 2'd0);
        check("t1_lat0", 64'(last_w.cyc), 64'(acc_cyc[3]));
        expect_word("t1_w1", 32'h04050607, 1'b0, 1'b0, 2'd0);
        check("t1_lat1", 64'(last_w.cyc), 64'(acc_cyc[7]));
        expect_word("t1_w2", 32'h08090A0B, 1'b0, 1'b1, 2'd0);
        check("t1_lat2", 64'(last_w.cyc), 64'(acc_cyc[11]));

        // T2: output stalled 10 cycles after the first word is produced
        fork
            send_seq(0, 12);
            begin
                bit seen = 1'b0;
                for (int t = 0; t < 100 && !seen; t++) begin
                    @(posedge clock_clk);
                    #1;
                    if (out_valid) seen = 1'b1;
                end
                if (!seen) check("t2_valid_timeout", 64'd0, 64'd1);
                out_ready = 1'b0;
                repeat (10) begin
                    @(posedge clock_clk);
                    #1;
                end
                check("t2_in_ready_k3", 64'(in_ready), 64'd0);
                out_ready = 1'b1;
            end
        join
        expect_word("t2_w0", 32'h00010203, 1'b1, 1'b0, 2'd0);
        expect_word("t2_w1", 32'h04050607, 1'b0, 1'b0, 2'd0);
        expect_word("t2_w2", 32'h08090A0B, 1'b0, 1'b1, 2'd0);

        // T3: 3 bytes then flush -> single short word
        pkt_len = 13'd2;
        send_seq(8'hA1, 3);
        do_flush();
        expect_word("t3_short", 32'hA1A2A300, 1'b1, 1'b1, 2'd1);
        repeat (3) @(posedge clock_clk);
        #1;
        check("t3_ack_once", 64'(ack_cnt), 64'd1);

        // T4: flush after one full word -> pad word, then a fresh packet
        send_seq(8'hB0, 4);
        expect_word("t4_w0", 32'hB0B1B2B3, 1'b1, 1'b0, 2'd0);
        do_flush();
        expect_word("t4_pad", 32'h00000000, 1'b0, 1'b1, 2'd3);
        send_seq(8'hC0, 4);
        expect_word("t4_new_sop", 32'hC0C1C2C3, 1'b1, 1'b0, 2'd0);
        send_seq(8'hD0, 4);
        expect_word("t4_new_eop", 32'hD0D1D2D3, 1'b0, 1'b1, 2'd0);
        check("t4_ack_cnt", 64'(ack_cnt), 64'd2);

        // T5: default length 64, pkt_len changed mid-packet
        pkt_len = 13'd0;
        send_seq(0, 100);
        pkt_len = 13'd5;
        send_seq(100, 156);
        send_seq(0, 20);
        for (int j = 0; j < 64; j++)
            expect_word($sformatf("t5_def_w%0d", j), mkw(4 * j), j == 0, j == 63, 2'd0);
        for (int j = 0; j < 5; j++)
            expect_word($sformatf("t5_len5_w%0d", j), mkw(4 * j), j == 0, j == 4, 2'd0);

        // T6: reset with one word held at the output and two bytes in the accumulator
        pkt_len = 13'd4;
        send_seq(8'h10, 4);
        expect_word("t6_w0", 32'h10111213, 1'b1, 1'b0, 2'd0);
        out_ready = 1'b0;
        send_seq(8'h14, 6);
        check("t6_pre_valid", 64'(out_valid), 64'd1);
        #2 reset_reset = 1'b1;
        #1;
        check("t6_rst_valid", 64'(out_valid), 64'd0);
        check("t6_rst_fields", {28'd0, out_data, out_sop, out_eop, out_empty}, 64'd0);
        check("t6_rst_in_ready", 64'(in_ready), 64'd0);
        @(posedge clock_clk);
        #1 reset_reset = 1'b0;
        out_ready = 1'b1;
        send_seq(8'hE0, 4);
        expect_word("t6_after_rst", 32'hE0E1E2E3, 1'b1, 1'b0, 2'd0);

        repeat (5) @(posedge clock_clk);
        #1;
        check("no_extra_words", 64'(words.size()), 64'd0);
        check("final_ack_cnt", 64'(ack_cnt), 64'd2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
